clk_ratio_detector: RTL and testbench

Measures the period of an incoming divided clock in `i_ref_clk` cycles and reports the division ratio plus a lock indication. It is the receive-side counterpart of the programmable clock divider in the RDI wake handshake path. The far end, or a loopback, checks that the divided clock actually runs at the programmed ratio before the wake handshake proceeds.

---
 rtl/clk_det_pkg.sv | 14 +
 rtl/bit_sync.sv | 21 ++
 rtl/clk_ratio_detector.sv | 143 ++++++++++++++
 tb/tb_clk_ratio_detector.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_det_pkg.sv
// Shared types and constants for the divided-clock ratio detector.
package clk_det_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE,
        LOCKED
    } state_t;

    localparam int unsigned MATCH_W        = 4;
    localparam int unsigned LOCK_COUNT_DEF = 4;

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous bit, reset to 0.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_ratio_detector.sv
// Measures the period of a divided clock in reference cycles and reports lock.
// Optional stopped-clock timeout enabled by defining CLK_DET_TIMEOUT_EN.
module clk_ratio_detector
    import clk_det_pkg::*;
#(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic                 i_ref_clk,
    input  logic                 i_rst,
    input  logic                 i_clk_en,
    input  logic                 i_div_clk,
    output logic [DIV_WIDTH-1:0] o_div_ratio,
    output logic                 o_ratio_valid,
    output logic                 o_locked
`ifdef CLK_DET_TIMEOUT_EN
    ,
    output logic                 o_timeout
`endif
);

    state_t               state;
    logic                 s2;
    logic                 s3;
    logic                 rise;
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] last;
    logic [MATCH_W-1:0]   match;
    logic [MATCH_W-1:0]   match_inc;
    logic                 lock_hit;

    bit_sync u_sync (
        .clk (i_ref_clk),
        .rst (i_rst),
        .d   (i_div_clk),
        .q   (s2)
    );

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            s3 <= 1'b0;
        end else begin
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Free-running, so at every rise cnt holds the just-finished period.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= DIV_WIDTH'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + DIV_WIDTH'(1);
        end
    end

    always_comb begin
        match_inc = MATCH_W'(1);
        if (match != '0 && cnt == last) begin
            match_inc = match + MATCH_W'(1);
        end
    end

    assign lock_hit = (match_inc == MATCH_W'(LOCK_COUNT));

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            o_div_ratio   <= '0;
            o_ratio_valid <= 1'b0;
            o_locked      <= 1'b0;
            match         <= '0;
            last          <= '0;
`ifdef CLK_DET_TIMEOUT_EN
            o_timeout     <= 1'b0;
`endif
        end else begin
            o_ratio_valid <= 1'b0;
`ifdef CLK_DET_TIMEOUT_EN
            o_timeout     <= 1'b0;
`endif
            if (!i_clk_en) begin
                state    <= IDLE;
                o_locked <= 1'b0;
                match    <= '0;
            end else begin
                case (state)
                    IDLE: state <= ARM;
                    ARM: begin
                        if (rise) begin
                            state <= MEASURE;
                            match <= '0;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            o_div_ratio   <= cnt;
                            o_ratio_valid <= 1'b1;
                            last          <= cnt;
                            match         <= match_inc;
                            if (lock_hit) begin
                                state    <= LOCKED;
                                o_locked <= 1'b1;
                            end
                        end
`ifdef CLK_DET_TIMEOUT_EN
                        else if (cnt == '1) begin
                            o_timeout <= 1'b1;
                            state     <= ARM;
                            match     <= '0;
                        end
`endif
                    end
                    LOCKED: begin
                        if (rise) begin
                            o_div_ratio   <= cnt;
                            o_ratio_valid <= 1'b1;
                            last          <= cnt;
                            if (cnt != last) begin
                                state    <= MEASURE;
                                o_locked <= 1'b0;
                                match    <= MATCH_W'(1);
                            end
                        end
`ifdef CLK_DET_TIMEOUT_EN
                        else if (cnt == '1) begin
                            o_timeout <= 1'b1;
                            state     <= ARM;
                            o_locked  <= 1'b0;
                            match     <= '0;
                        end
`endif
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_ratio_detector.sv
// Directed bench for clk_ratio_detector; covers CLK_DET_TIMEOUT_EN builds too.
module tb_clk_ratio_detector;

    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          div;
    logic [DW-1:0] ratio;
    logic          valid;
    logic          locked;
`ifdef CLK_DET_TIMEOUT_EN
    logic          timeout;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int iter, nvalid, first_valid_iter, first_ratio, last_ratio;
    int fall_iter, rise_iter, tmo_iter, ntmo;
    logic prev_locked;

    clk_ratio_detector #(
        .DIV_WIDTH  (DW),
        .LOCK_COUNT (4)
    ) dut (
        .i_ref_clk     (clk),
        .i_rst         (rst),
        .i_clk_en      (en),
        .i_div_clk     (div),
        .o_div_ratio   (ratio),
        .o_ratio_valid (valid),
        .o_locked      (locked)
`ifdef CLK_DET_TIMEOUT_EN
        ,
        .o_timeout     (timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        iter = 0; nvalid = 0; first_valid_iter = -1; first_ratio = -1; last_ratio = -1;
        fall_iter = -1; rise_iter = -1; tmo_iter = -1; ntmo = 0;
        prev_locked = locked;
    endtask

    // One reference cycle: drive div, then sample outputs 1 time unit after the edge.
    task automatic step(input logic d);
        div = d;
        @(posedge clk);
        #1;
        if (valid) begin
            if (nvalid == 0) begin
                first_valid_iter = iter;
                first_ratio      = int'(ratio);
            end
            nvalid++;
            last_ratio = int'(ratio);
        end
        if (prev_locked && !locked && fall_iter < 0) fall_iter = iter;
        if (!prev_locked && locked) rise_iter = iter;
        prev_locked = locked;
`ifdef CLK_DET_TIMEOUT_EN
        if (timeout) begin
            if (ntmo == 0) tmo_iter = iter;
            ntmo++;
        end
`endif
        iter++;
    endtask

    task automatic run(input int n, input int h, input int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < n; i++)
                step(i < h);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; div = 1'b0;
        #3;
        check("rst_ratio", int'(ratio), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_locked", int'(locked), 0);
`ifdef CLK_DET_TIMEOUT_EN
        check("rst_timeout", int'(timeout), 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        en  = 1'b1;
        step(0); step(0);

        // Ratio 8: first report 8 cycles after arming, lock after the 4th period.
        clear_obs();
        run(8, 4, 6);
        check("r8_first_iter", first_valid_iter, 10);
        check("r8_first_ratio", first_ratio, 8);
        check("r8_nvalid", nvalid, 5);
        check("r8_lock_iter", rise_iter, 34);
        check("r8_no_fall", fall_iter, -1);

        // Ratio 5: lock drops on first mismatch, relocks after 4 periods.
        clear_obs();
        run(5, 3, 6);
        check("r5_first_ratio", first_ratio, 8);
        check("r5_last_ratio", last_ratio, 5);
        check("r5_nvalid", nvalid, 6);
        check("r5_fall_iter", fall_iter, 7);
        check("r5_lock_iter", rise_iter, 22);

        // Ratio 12.
        clear_obs();
        run(12, 6, 5);
        check("r12_nvalid", nvalid, 5);
        check("r12_fall_iter", fall_iter, 14);
        check("r12_lock_iter", rise_iter, 50);
        check("r12_last_ratio", last_ratio, 12);

        // Jitter 6,7,6,7,...: every edge reports, never locks.
        clear_obs();
        for (int p = 0; p < 3; p++) begin
            run(6, 3, 1);
            run(7, 3, 1);
        end
        check("jit_nvalid", nvalid, 6);
        check("jit_fall_iter", fall_iter, 8);
        check("jit_no_lock", rise_iter, -1);
        check("jit_last_ratio", last_ratio, 6);

        // Relock at 8, then stop the divided clock.
        clear_obs();
        run(8, 4, 5);
        check("re8_lock_iter", rise_iter, 34);
        check("re8_nvalid", nvalid, 5);
        clear_obs();
        for (int i = 0; i < 300; i++) step(0);
        check("stop_nvalid", nvalid, 0);
`ifdef CLK_DET_TIMEOUT_EN
        check("stop_tmo_iter", tmo_iter, 249);
        check("stop_tmo_count", ntmo, 1);
        check("stop_fall_iter", fall_iter, 249);
        check("stop_locked", int'(locked), 0);
`else
        check("stop_no_fall", fall_iter, -1);
        check("stop_locked", int'(locked), 1);
`endif
        clear_obs();
        run(8, 4, 5);
        check("restart_lock_iter", rise_iter, 34);
`ifdef CLK_DET_TIMEOUT_EN
        check("restart_first_iter", first_valid_iter, 10);
        check("restart_first_ratio", first_ratio, 8);
        check("restart_nvalid", nvalid, 4);
`else
        check("restart_first_iter", first_valid_iter, 2);
        check("restart_first_ratio", first_ratio, 255);
        check("restart_fall_iter", fall_iter, 2);
        check("restart_nvalid", nvalid, 5);
`endif

        // Enable drop mid-period while locked.
        clear_obs();
        repeat (4) step(1);
        en = 1'b0;
        repeat (4) step(0);
        run(8, 4, 3);
        check("en_fall_iter", fall_iter, 4);
        check("en_nvalid", nvalid, 1);
        check("en_ratio_hold", int'(ratio), 8);
        check("en_locked", int'(locked), 0);

        // Enable falls in the same cycle the FSM would act on rise: no report.
        en = 1'b1;
        step(0); step(0);
        clear_obs();
        run(8, 4, 2);
        step(1); step(1);
        en = 1'b0;
        step(1); step(1);
        check("sim_nvalid", nvalid, 1);
        check("sim_first_iter", first_valid_iter, 10);

        // Asynchronous reset mid-period while locked.
        en = 1'b1;
        step(0); step(0);
        clear_obs();
        run(8, 4, 6);
        check("pre_rst_lock_iter", rise_iter, 34);
        step(1); step(1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_ratio", int'(ratio), 0);
        check("arst_locked", int'(locked), 0);
        check("arst_valid", int'(valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
